// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared definitions for the decoder row-scan sequencer: row geometry and FSM encoding.
package decoder_scan_sequencer_pkg;
    localparam int ROWS  = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_t;
endpackage

// File: rtl/decoder_scan_sequencer_next_row.sv
// Next enabled row strictly above cur; wraps to the lowest enabled row when none is above.
// With cur = ROWS-1 it yields the first row of a mask.
module scan_next_row
    import decoder_scan_sequencer_pkg::*;
(
    input  logic [ROWS-1:0]  mask,
    input  logic [SEL_W-1:0] cur,
    output logic [SEL_W-1:0] nxt,
    output logic             wrap
);
    logic [SEL_W-1:0] above;
    logic [SEL_W-1:0] lowest;
    logic             found;

    // Descending scans so the last hit is the lowest qualifying bit.
    always_comb begin
        above  = '0;
        lowest = '0;
        found  = 1'b0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (mask[i] && (SEL_W'(i) > cur)) begin
                above = SEL_W'(i);
                found = 1'b1;
            end
            if (mask[i]) begin
                lowest = SEL_W'(i);
            end
        end
        wrap = !found;
        nxt  = found ? above : lowest;
    end
endmodule

// File: rtl/decoder_scan_sequencer.sv
// Row-scan driver for a 3-to-8 decoder: dwell per enabled row, blank between rows,
// select only moves while the enable is low.
module decoder_scan_sequencer
    import decoder_scan_sequencer_pkg::*;
#(
    parameter int DWELL_W      = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [ROWS-1:0]    row_mask,
    output logic               dec_en,
    output logic [SEL_W-1:0]   dec_sel,
    output logic               busy,
    output logic               frame_done
);
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES + 1) : 1;

    scan_state_t        state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [BW-1:0]      bcnt_q, bcnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [ROWS-1:0]    mask_q, mask_d;
    logic               dec_en_d, busy_d, frame_done_d;
    logic [SEL_W-1:0]   dec_sel_d;

    logic [SEL_W-1:0]   nxt_row, first_row;
    logic               row_wrap, first_wrap_unused;
    logic               dwell_last, blank_last, start_ok, new_mask_empty;
    logic [DWELL_W-1:0] new_dwell;

    scan_next_row u_next (
        .mask (mask_q),
        .cur  (dec_sel),
        .nxt  (nxt_row),
        .wrap (row_wrap)
    );

    // First row of the incoming mask, used at start and at every frame wrap.
    scan_next_row u_first (
        .mask (row_mask),
        .cur  (SEL_W'(ROWS - 1)),
        .nxt  (first_row),
        .wrap (first_wrap_unused)
    );

    assign dwell_last     = (cnt_q == dwell_q);
    assign blank_last     = (bcnt_q == BW'(BLANK_CYCLES));
    assign new_mask_empty = (row_mask == '0);
    assign start_ok       = start && !stop && !new_mask_empty;
    assign new_dwell      = (dwell == '0) ? DWELL_W'(1) : dwell;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bcnt_q     <= '0;
            dwell_q    <= '0;
            mask_q     <= '0;
            dec_en     <= 1'b0;
            dec_sel    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bcnt_q     <= bcnt_d;
            dwell_q    <= dwell_d;
            mask_q     <= mask_d;
            dec_en     <= dec_en_d;
            dec_sel    <= dec_sel_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start_ok) state_d = ST_DWELL;
                ST_DWELL: begin
                    if (dwell_last) begin
                        if (row_wrap && new_mask_empty) state_d = ST_IDLE;
                        else if (BLANK_CYCLES > 0)      state_d = ST_BLANK;
                        else                            state_d = ST_DWELL;
                    end
                end
                ST_BLANK: if (blank_last) state_d = ST_DWELL;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        bcnt_d       = bcnt_q;
        dwell_d      = dwell_q;
        mask_d       = mask_q;
        dec_en_d     = dec_en;
        dec_sel_d    = dec_sel;
        busy_d       = busy;
        frame_done_d = 1'b0;
        if (stop) begin
            dec_en_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        dwell_d   = new_dwell;
                        mask_d    = row_mask;
                        dec_sel_d = first_row;
                        dec_en_d  = 1'b1;
                        busy_d    = 1'b1;
                        cnt_d     = DWELL_W'(1);
                    end
                end
                ST_DWELL: begin
                    if (dwell_last) begin
                        cnt_d  = DWELL_W'(1);
                        bcnt_d = BW'(1);
                        // Frame boundary: the only point where dwell/mask are re-sampled.
                        if (row_wrap) begin
                            frame_done_d = 1'b1;
                            dwell_d      = new_dwell;
                            mask_d       = row_mask;
                        end
                        if (row_wrap && new_mask_empty) begin
                            dec_en_d = 1'b0;
                            busy_d   = 1'b0;
                        end else begin
                            dec_sel_d = row_wrap ? first_row : nxt_row;
                            dec_en_d  = (BLANK_CYCLES == 0);
                        end
                    end else begin
                        cnt_d = cnt_q + DWELL_W'(1);
                    end
                end
                ST_BLANK: begin
                    if (blank_last) begin
                        dec_en_d = 1'b1;
                        cnt_d    = DWELL_W'(1);
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end
                default: begin
                    dec_en_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Bench for decoder_scan_sequencer: frame-schedule queue model, per-cycle compare, directed pins.
module tb_decoder_scan_sequencer;
    localparam int DWELL_W = 8;
    localparam int BLANK   = 2;

    typedef struct packed {
        logic       en;
        logic [2:0] sel;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] dwell = 8'd0;
    logic [7:0] row_mask = 8'd0;
    logic       dec_en, busy, frame_done;
    logic [2:0] dec_sel;

    decoder_scan_sequencer #(.DWELL_W(DWELL_W), .BLANK_CYCLES(BLANK)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .dwell      (dwell),
        .row_mask   (row_mask),
        .dec_en     (dec_en),
        .dec_sel    (dec_sel),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs = 0;
    int cyc = 0;
    int last_fd = -1;
    logic       m_en = 1'b0, m_busy = 1'b0, m_fd = 1'b0, m_scan = 1'b0;
    logic [2:0] m_sel = 3'd0;
    logic       prev_en = 1'b0;
    logic [2:0] prev_sel = 3'd0;
    ent_t q[$];
    int   fd_gap[$];
    int   seq[$];

    function automatic logic [2:0] lowest(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) if (m[i]) r = 3'(i);
        return r;
    endfunction

    // One frame's worth of per-cycle outputs, up to the last dwell cycle of the last row.
    task automatic build(input logic [7:0] m, input logic [7:0] d);
        int   rows[$];
        int   dd;
        ent_t e;
        dd = (d == 8'd0) ? 1 : int'(d);
        for (int i = 0; i < 8; i++) if (m[i]) rows.push_back(i);
        for (int k = 0; k < rows.size(); k++) begin
            e.en = 1'b1; e.sel = 3'(rows[k]);
            repeat (dd) q.push_back(e);
            if (k + 1 < rows.size()) begin
                e.en = 1'b0; e.sel = 3'(rows[k+1]);
                repeat (BLANK) q.push_back(e);
            end
        end
    endtask

    task automatic pop();
        ent_t e;
        e = q.pop_front();
        m_en = e.en; m_sel = e.sel; m_busy = 1'b1;
    endtask

    task automatic model_step();
        ent_t e;
        m_fd = 1'b0;
        if (rst) begin
            m_en = 1'b0; m_sel = 3'd0; m_busy = 1'b0; m_scan = 1'b0; q.delete();
        end else if (stop) begin
            m_en = 1'b0; m_busy = 1'b0; m_scan = 1'b0; q.delete();
        end else if (!m_scan) begin
            if (start && row_mask != 8'd0) begin
                build(row_mask, dwell); m_scan = 1'b1; pop();
            end
        end else if (q.size() != 0) begin
            pop();
        end else begin
            m_fd = 1'b1;
            if (row_mask == 8'd0) begin
                m_scan = 1'b0; m_en = 1'b0; m_busy = 1'b0;
            end else begin
                e.en = 1'b0; e.sel = lowest(row_mask);
                repeat (BLANK) q.push_back(e);
                build(row_mask, dwell);
                pop();
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        vectors++;
        if ({dec_en, dec_sel, busy, frame_done} !== {m_en, m_sel, m_busy, m_fd}) begin
            errs++;
            $display("FAIL outputs cyc %0d: en/sel/busy/fd got %b/%0d/%b/%b expected %b/%0d/%b/%b",
                     cyc, dec_en, dec_sel, busy, frame_done, m_en, m_sel, m_busy, m_fd);
        end
        if (prev_en && dec_en) begin
            vectors++;
            if (dec_sel !== prev_sel) begin
                errs++;
                $display("FAIL sel_stable cyc %0d: sel got %0d expected %0d", cyc, dec_sel, prev_sel);
            end
        end
        if (frame_done) begin
            if (last_fd >= 0) fd_gap.push_back(cyc - last_fd);
            last_fd = cyc;
        end
        if (dec_en && !prev_en) seq.push_back(int'(dec_sel));
        prev_en = dec_en; prev_sel = dec_sel;
    endtask

    task automatic clr();
        fd_gap.delete(); seq.delete(); last_fd = -1;
    endtask

    task automatic go_idle();
        stop = 1'b1; tick(); stop = 1'b0; clr();
    endtask

    task automatic kick(input logic [7:0] m, input logic [7:0] d);
        row_mask = m; dwell = d; start = 1'b1; tick(); start = 1'b0;
    endtask

    initial begin
        int n;
        int r;
        // Reset held with start pulsed: everything stays at zero.
        rst = 1'b1; start = 1'b1; row_mask = 8'hFF; dwell = 8'd3;
        repeat (2) begin
            tick();
            check("rst_en", int'(dec_en), 0);
            check("rst_sel", int'(dec_sel), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_fd", int'(frame_done), 0);
        end
        rst = 1'b0; start = 1'b0; tick();

        // Full mask, dwell 3: rows 0..7, 40-cycle frame.
        clr(); kick(8'hFF, 8'd3);
        repeat (90) tick();
        check("t2_seq_len_ok", int'(seq.size() >= 8), 1);
        if (seq.size() >= 8) begin
            check("t2_seq0", seq[0], 0);
            check("t2_seq3", seq[3], 3);
            check("t2_seq7", seq[7], 7);
        end
        check("t2_gap_cnt_ok", int'(fd_gap.size() >= 1), 1);
        if (fd_gap.size() >= 1) check("t2_period", fd_gap[0], 40);

        // Sparse mask, dwell 1 and dwell 0 behave identically.
        for (int d = 1; d >= 0; d--) begin
            go_idle(); kick(8'b1010_0100, 8'(d));
            repeat (20) tick();
            check("t3_seq_len_ok", int'(seq.size() >= 4), 1);
            if (seq.size() >= 4) begin
                check("t3_seq0", seq[0], 2);
                check("t3_seq1", seq[1], 5);
                check("t3_seq2", seq[2], 7);
                check("t3_seq3", seq[3], 2);
            end
            if (fd_gap.size() >= 1) check("t3_period", fd_gap[0], 9);
        end

        // Mask change mid-frame takes effect only after the wrap.
        go_idle(); kick(8'hFF, 8'd2);
        repeat (10) tick();
        row_mask = 8'h01;
        repeat (60) tick();
        check("t4_gap_cnt_ok", int'(fd_gap.size() >= 2), 1);
        if (fd_gap.size() >= 2) check("t4_period", fd_gap[fd_gap.size()-1], 4);
        if (seq.size() >= 3) check("t4_last_row", seq[seq.size()-1], 0);

        // Stop during row 4 dwell; then start+stop together stays idle.
        go_idle(); kick(8'hFF, 8'd5);
        n = 0;
        while (!(dec_en && dec_sel == 3'd4) && n < 100) begin tick(); n++; end
        check("t5_reach_row4", int'(n < 100), 1);
        stop = 1'b1; tick(); stop = 1'b0;
        check("t5_en", int'(dec_en), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_sel", int'(dec_sel), 4);
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        check("t5_ss_busy", int'(busy), 0);
        tick();

        // Reset mid-blank, then start with empty mask.
        go_idle(); kick(8'hFF, 8'd2);
        n = 0;
        while (!(busy && !dec_en) && n < 50) begin tick(); n++; end
        check("t6_reach_blank", int'(n < 50), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("t6_en", int'(dec_en), 0);
        check("t6_sel", int'(dec_sel), 0);
        check("t6_busy", int'(busy), 0);
        kick(8'h00, 8'd3); tick();
        check("t6_empty_busy", int'(busy), 0);

        // Maximum dwell does not overflow the counter.
        go_idle(); kick(8'h10, 8'd255);
        repeat (600) tick();
        if (fd_gap.size() >= 1) check("t8_period", fd_gap[0], 257);
        else check("t8_gap_cnt_ok", 0, 1);

        // Randomized traffic against the model.
        for (int it = 0; it < 25; it++) begin
            kick(($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom), 8'($urandom_range(0, 5)));
            for (int c = 0; c < 60; c++) begin
                r = $urandom_range(0, 99);
                start = (r < 8);
                stop  = (r >= 8 && r < 11);
                rst   = (r == 11);
                if (r >= 12 && r < 16) row_mask = 8'($urandom);
                if (r >= 16 && r < 19) dwell = 8'($urandom_range(0, 4));
                tick();
            end
            start = 1'b0; stop = 1'b0; rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
